// File: rtl/rom_loader.sv
// rom_loader: streams a Hack program into the instruction ROM.
// Byte pairs (high byte first) are assembled into 16-bit words and written to
// consecutive ROM addresses starting at 0. The CPU is held in reset while the
// load runs, and a 16-bit running checksum of the written words is kept.
module rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Largest legal load: the whole ROM, 2^ADDR_WIDTH words.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]          state_q;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_inc;
  logic [7:0]          hi_q;

  // Words written once the word currently in WRITE is committed.
  assign count_inc = count_q + 1'b1;

  // Moore outputs decoded from the state register only.
  assign byte_ready = (state_q == S_HI) || (state_q == S_LO);
  assign rom_we     = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign cpu_reset  = (state_q != S_IDLE);

  // Load sequencer: word assembly, address/count stepping and checksum.
  always_ff @(posedge clock) begin
    // NOTE: every register here is sequential state, so all updates use <=;
    // data registers are reset too, so the ROM port shows 0 after reset and a
    // half-assembled word can never leak into a later write.
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      rom_addr <= '0;
      rom_data <= '0;
      checksum <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q    <= (len > MAX_LEN) ? MAX_LEN : len;
              count_q  <= '0;
              rom_addr <= '0;
              checksum <= '0;
              busy     <= 1'b1;
              state_q  <= S_HI;
            end else begin
              // Empty program: pulse done without ever looking busy.
              state_q <= S_DONE;
            end
          end
        end
        S_HI: begin
          if (byte_valid) begin
            hi_q    <= byte_in;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (byte_valid) begin
            rom_data <= {hi_q, byte_in};
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          checksum <= checksum + rom_data;
          count_q  <= count_inc;
          if (count_inc == len_q) begin
            // Address is left on the last written word; it never wraps.
            state_q <= S_DONE;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state_q  <= S_HI;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
